bit_packer_compression: RTL and testbench

//   Packs variable-length Huffman/Deflate codes, LSB-first, into fixed-width output words.

---
 rtl/bit_packer_compression.sv | 119 +++++++++++
 tb/tb_bit_packer_compression.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_packer_compression.sv
// Packs variable-length codes LSB-first into OUT_W-bit words; in_last byte-aligns the
// stream with zero padding and emits the final partial word with its byte count.
module bit_packer_compression #(
  parameter int IN_W   = 32,
  parameter int OUT_W  = 32,
  parameter int LEN_W  = 6,
  parameter int BYTE_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [BYTE_W-1:0] out_bytes,
  output logic              out_last
);

  localparam int ACC_W = OUT_W + IN_W;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0]  C_OUT_W  = CNT_W'(OUT_W);
  localparam logic [LEN_W-1:0]  C_IN_W   = LEN_W'(IN_W);
  localparam logic [BYTE_W-1:0] C_FULL_B = BYTE_W'(OUT_W / 8);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t              r_state, w_state_nxt;
  logic [ACC_W-1:0]    r_acc, w_acc_nxt;
  logic [CNT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic                r_out_valid, w_out_valid_nxt;
  logic [OUT_W-1:0]    r_out_data, w_out_data_nxt;
  logic [BYTE_W-1:0]   r_out_bytes, w_out_bytes_nxt;
  logic                r_out_last, w_out_last_nxt;

  logic                w_fire;
  logic                w_free;
  logic [LEN_W-1:0]    w_len;
  logic [IN_W-1:0]     w_masked;
  logic [CNT_W-1:0]    w_rem_bytes;

  assign in_ready    = reset & (r_state == S_RUN) & (r_bit_cnt < C_OUT_W);
  assign w_fire      = in_valid & in_ready;
  assign w_free      = ~r_out_valid | out_ready;
  assign w_len       = (in_len > C_IN_W) ? C_IN_W : in_len;
  assign w_rem_bytes = (r_bit_cnt + CNT_W'(7)) >> 3;

  always_comb begin
    for (int i = 0; i < IN_W; i++) begin
      w_masked[i] = in_data[i] & (i < int'(w_len));
    end
  end

  always_comb begin
    // NOTE: every next-state value is defaulted first, so no path can infer a latch.
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_out_valid_nxt = r_out_valid & ~out_ready;
    w_out_data_nxt  = r_out_data;
    w_out_bytes_nxt = r_out_bytes;
    w_out_last_nxt  = r_out_last;

    if (w_fire) begin
      w_acc_nxt     = r_acc | (ACC_W'(w_masked) << r_bit_cnt);
      w_bit_cnt_nxt = r_bit_cnt + CNT_W'(w_len);
      if (in_last) w_state_nxt = S_FLUSH;
    end else if (w_free) begin
      if ((r_state == S_RUN && r_bit_cnt >= C_OUT_W) ||
          (r_state == S_FLUSH && r_bit_cnt > C_OUT_W)) begin
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = r_acc[OUT_W-1:0];
        w_out_bytes_nxt = C_FULL_B;
        w_out_last_nxt  = 1'b0;
        w_acc_nxt       = r_acc >> OUT_W;
        w_bit_cnt_nxt   = r_bit_cnt - C_OUT_W;
      end else if (r_state == S_FLUSH) begin
        // Bits at and above bit_cnt are always zero in acc, so this is already padded.
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = r_acc[OUT_W-1:0];
        w_out_bytes_nxt = BYTE_W'(w_rem_bytes);
        w_out_last_nxt  = 1'b1;
        w_acc_nxt       = '0;
        w_bit_cnt_nxt   = '0;
        w_state_nxt     = S_RUN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_RUN;
      r_acc       <= '0;
      r_bit_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_bytes <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_bytes <= w_out_bytes_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_bytes = r_out_bytes;
  assign out_last  = r_out_last;

endmodule

// File: tb/tb_bit_packer_compression.sv
// Bench for bit_packer_compression: directed cases plus random codes checked against a
// bit-queue reference model of the packed stream.
module tb_bit_packer_compression;

  localparam int IN_W = 32, OUT_W = 32, LEN_W = 6, BYTE_W = 3;

  logic clk = 1'b0, reset = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [IN_W-1:0]   in_data = '0;
  logic [LEN_W-1:0]  in_len = '0;
  logic              in_ready, out_valid, out_last;
  logic [OUT_W-1:0]  out_data;
  logic [BYTE_W-1:0] out_bytes;

  bit_packer_compression #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W), .BYTE_W(BYTE_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_bytes(out_bytes), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          bytes;
    bit          last;
  } word_t;

  bit    bq[$];
  word_t exp_q[$];
  word_t cap_q[$];
  int    n_cmp = 0, n_bad = 0;
  bit    done = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the stream is a plain queue of bits; words are cut off its front.
  function automatic void emit(input bit last);
    word_t w;
    int n = last ? bq.size() : OUT_W;
    w.data = '0;
    for (int i = 0; i < n; i++) w.data[i] = bq.pop_front();
    w.bytes = (n + 7) / 8;
    w.last  = last;
    exp_q.push_back(w);
  endfunction

  function automatic void model_push(input logic [31:0] d, input int l, input bit last);
    int len = (l > IN_W) ? IN_W : l;
    for (int i = 0; i < len; i++) bq.push_back(d[i]);
    while (bq.size() > OUT_W || (!last && bq.size() == OUT_W)) emit(1'b0);
    if (last) emit(1'b1);
  endfunction

  logic        stall = 1'b0;
  logic [31:0] hold_d;
  logic [2:0]  hold_b;
  logic        hold_l;
  word_t       mon_w, mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_data", out_data, hold_d);
        check("hold_bytes", out_bytes, hold_b);
        check("hold_last", out_last, hold_l);
      end
      if (in_valid && in_ready) model_push(in_data, int'(in_len), in_last);
      if (out_valid && out_ready) begin
        mon_w.data = out_data; mon_w.bytes = int'(out_bytes); mon_w.last = out_last;
        cap_q.push_back(mon_w);
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("out_data", out_data, mon_e.data);
          check("out_bytes", out_bytes, mon_e.bytes);
          check("out_last", out_last, mon_e.last);
        end
      end
      stall  = out_valid & ~out_ready;
      hold_d = out_data;
      hold_b = out_bytes;
      hold_l = out_last;
    end
  end

  task automatic send(input logic [31:0] d, input int l, input bit last);
    int n = 0;
    in_data = d; in_len = LEN_W'(l); in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_accepted", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || bq.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", n < 2000, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_bytes", out_bytes, 0);
    check("rst_out_last", out_last, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Eight byte codes, free-running output
    out_ready = 1'b1;
    cap_q.delete();
    for (int i = 0; i < 8; i++) send(32'(i), 8, 1'b0);
    wait_idle();
    check("t1_count", cap_q.size(), 2);
    check("t1_w0", cap_q[0].data, 32'h03020100);
    check("t1_w1", cap_q[1].data, 32'h07060504);
    check("t1_bytes", cap_q[1].bytes, 4);
    check("t1_last", cap_q[1].last, 0);

    // Short block flush
    cap_q.delete();
    send(32'h5, 3, 1'b0);
    send(32'h1A, 5, 1'b1);
    wait_idle();
    check("t2_count", cap_q.size(), 1);
    check("t2_data", cap_q[0].data, 32'h000000D5);
    check("t2_bytes", cap_q[0].bytes, 1);
    check("t2_last", cap_q[0].last, 1);

    // Backpressure with full-width codes
    cap_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send($urandom(), 32, 1'b0);
      end
      begin
        repeat (10) @(negedge clk);
        check("t3_stall_in_ready", in_ready, 0);
        check("t3_stall_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_idle();
    check("t3_count", cap_q.size(), 4);

    // Masking and length saturation
    cap_q.delete();
    send(32'hFFFFFFFF, 4, 1'b0);
    send(32'h0000FFFF, 0, 1'b0);
    send(32'h0, 63, 1'b0);
    send(32'h0, 0, 1'b1);
    wait_idle();
    check("t4_count", cap_q.size(), 2);
    check("t4_w0", cap_q[0].data, 32'h0000000F);
    check("t4_w0_bytes", cap_q[0].bytes, 4);
    check("t4_w1", cap_q[1].data, 32'h0);
    check("t4_w1_bytes", cap_q[1].bytes, 1);
    check("t4_w1_last", cap_q[1].last, 1);

    // Empty block
    cap_q.delete();
    send(32'hFFFFFFFF, 0, 1'b1);
    wait_idle();
    check("t5_count", cap_q.size(), 1);
    check("t5_data", cap_q[0].data, 32'h0);
    check("t5_bytes", cap_q[0].bytes, 0);
    check("t5_last", cap_q[0].last, 1);
    @(negedge clk);
    check("t5_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Reset while a flush is pending behind a held word
    out_ready = 1'b0;
    send(32'hDEADBEEF, 32, 1'b0);
    send(32'h11, 8, 1'b1);
    @(negedge clk);
    check("t6_pre_out_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_in_ready", in_ready, 0);
    check("t6_rst_out_last", out_last, 0);
    bq.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    out_ready = 1'b1;
    cap_q.delete();
    @(posedge clk); #1;
    send(32'hAB, 8, 1'b1);
    wait_idle();
    check("t6_count", cap_q.size(), 1);
    check("t6_data", cap_q[0].data, 32'h000000AB);
    check("t6_bytes", cap_q[0].bytes, 1);

    // Random codes with random gaps and random backpressure
    fork
      begin
        for (int k = 0; k < 400; k++) begin
          int gap = $urandom_range(0, 2);
          if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
          end
          send($urandom(), $urandom_range(0, 40), ($urandom_range(0, 9) == 0) || (k == 399));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
